// File: rtl/spi_slave_rx.sv
// SPI mode-3 receive endpoint: oversamples sclk/mosi/cs in the clk domain and assembles 8- or 32-bit words.
// Define SPI_SLAVE_RX_SYNC_EN to add two-flop synchronisers on the SPI pins (default: pins used directly).
module spi_slave_rx #(
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sclk,
  input  logic        mosi,
  input  logic        cs,
  input  logic        is_data_u8,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overrun,
  output logic        frame_error,
  output logic        is_busy,
  output logic [1:0]  state_dbg
);

  // Output handshake: a word transfers on any rising clk edge where out_valid && out_ready;
  // out_valid never drops without a transfer, and out_data is stable while out_valid is high.

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int GW = $clog2(IDLE_TIMEOUT + 1);

  logic          sclk_c, mosi_c, cs_c;
  logic          sclk_q;
  logic          sclk_rise;
  state_t        state, state_next;
  logic [2:0]    bit_cnt;
  logic [1:0]    byte_cnt;
  logic [31:0]   shift_reg;
  logic [31:0]   shift_next;
  logic [GW-1:0] gap_cnt;
  logic          u8_q;
  logic          u8_eff;
  logic          shift_en;
  logic          word_done;
  logic          load;
  logic          ferr_next;

`ifdef SPI_SLAVE_RX_SYNC_EN
  logic [1:0] sclk_sync, mosi_sync, cs_sync;

  // Idle levels of the bus (sclk high, cs high) so reset release does not fake an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= 2'b11;
      cs_sync   <= 2'b11;
      mosi_sync <= 2'b00;
    end else begin
      sclk_sync <= {sclk_sync[0], sclk};
      cs_sync   <= {cs_sync[0], cs};
      mosi_sync <= {mosi_sync[0], mosi};
    end
  end

  assign sclk_c = sclk_sync[1];
  assign cs_c   = cs_sync[1];
  assign mosi_c = mosi_sync[1];
`else
  assign sclk_c = sclk;
  assign cs_c   = cs;
  assign mosi_c = mosi;
`endif

  assign sclk_rise  = sclk_c && !sclk_q;
  assign shift_en   = sclk_rise && !cs_c;
  assign shift_next = {shift_reg[30:0], mosi_c};
  // Word width is sampled on the very first bit of a word, otherwise the latched copy holds.
  assign u8_eff     = (bit_cnt == 3'd0 && byte_cnt == 2'd0) ? is_data_u8 : u8_q;
  assign word_done  = shift_en && (bit_cnt == 3'd7) && (u8_eff || byte_cnt == 2'd3);
  assign load       = word_done && (!out_valid || out_ready);
  assign is_busy    = (state != ST_IDLE);
  assign state_dbg  = state;

  always_comb begin
    state_next = state;
    ferr_next  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!cs_c) state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (cs_c) begin
          if (bit_cnt != 3'd0) begin
            ferr_next  = 1'b1;
            state_next = ST_IDLE;
          end else if (byte_cnt != 2'd0) begin
            state_next = ST_GAP;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (!cs_c) begin
          state_next = ST_SHIFT;
        end else if (gap_cnt == GW'(IDLE_TIMEOUT - 1)) begin
          ferr_next  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      sclk_q      <= 1'b1;
      bit_cnt     <= 3'd0;
      byte_cnt    <= 2'd0;
      shift_reg   <= 32'h0;
      gap_cnt     <= '0;
      u8_q        <= 1'b0;
      out_data    <= 32'h0;
      out_valid   <= 1'b0;
      overrun     <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state       <= state_next;
      sclk_q      <= sclk_c;
      frame_error <= ferr_next;
      overrun     <= word_done && !load;
      gap_cnt     <= (state == ST_GAP) ? gap_cnt + 1'b1 : '0;

      if (ferr_next) begin
        bit_cnt   <= 3'd0;
        byte_cnt  <= 2'd0;
        shift_reg <= 32'h0;
      end else if (shift_en) begin
        shift_reg <= shift_next;
        bit_cnt   <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd0 && byte_cnt == 2'd0) u8_q <= is_data_u8;
        if (bit_cnt == 3'd7) byte_cnt <= word_done ? 2'd0 : byte_cnt + 2'd1;
      end

      if (load) begin
        out_data  <= u8_eff ? {24'h0, shift_next[7:0]} : shift_next;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: drives mode-3 SPI frames and checks words, pulses and busy.
module tb_spi_slave_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b1;
  logic        mosi = 1'b0;
  logic        cs = 1'b1;
  logic        is_data_u8 = 1'b1;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        overrun;
  logic        frame_error;
  logic        is_busy;
  logic [1:0]  state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int valid_cyc = 0;
  int ovr_cnt   = 0;
  int ferr_cnt  = 0;

  spi_slave_rx dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .mosi(mosi), .cs(cs),
    .is_data_u8(is_data_u8), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .overrun(overrun), .frame_error(frame_error),
    .is_busy(is_busy), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // monitor: samples on the falling edge, away from the DUT's active edge
  always @(negedge clk) begin
    if (out_valid) valid_cyc++;
    if (out_valid && out_ready) got_q.push_back(out_data);
    if (overrun) ovr_cnt++;
    if (frame_error) ferr_cnt++;
  end

  // driver tasks: inputs change 2 ns after the rising edge
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sclk = 1'b0;
      mosi = v[i];
      tick(4);
      sclk = 1'b1;
      tick(4);
    end
  endtask

  task automatic cs_low();
    cs = 1'b0;
    tick(4);
  endtask

  task automatic cs_high();
    tick(4);
    cs = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL reset_out_data got=%h exp=%h", out_data, 32'h0); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    n_cmp++; if (frame_error !== 1'b0) begin n_err++; $display("FAIL reset_frame_error got=%b exp=0", frame_error); end
    n_cmp++; if (is_busy !== 1'b0) begin n_err++; $display("FAIL reset_is_busy got=%b exp=0", is_busy); end
    rst_n = 1'b1;
    tick(4);
  endtask

  task automatic test_u8();
    int b_words, b_vc, b_f, b_o;
    logic [31:0] e;
    b_words = got_q.size(); b_vc = valid_cyc; b_f = ferr_cnt; b_o = ovr_cnt;
    is_data_u8 = 1'b1; out_ready = 1'b1;
    exp_q.push_back(32'h0000_00A5);
    cs_low(); send_bits(32'hA5, 8); cs_high(); tick(10);
    n_cmp++; if (got_q.size() - b_words !== 1) begin n_err++; $display("FAIL u8_word_count got=%0d exp=1", got_q.size() - b_words); end
    e = exp_q.pop_front();
    n_cmp++; if (got_q.size() > b_words && got_q[b_words] !== e) begin n_err++; $display("FAIL u8_data got=%h exp=%h", got_q[b_words], e); end
    n_cmp++; if (valid_cyc - b_vc !== 1) begin n_err++; $display("FAIL u8_valid_cycles got=%0d exp=1", valid_cyc - b_vc); end
    n_cmp++; if (ferr_cnt - b_f !== 0 || ovr_cnt - b_o !== 0) begin n_err++; $display("FAIL u8_no_pulses ferr=%0d ovr=%0d exp=0/0", ferr_cnt - b_f, ovr_cnt - b_o); end
  endtask

  task automatic test_u32_gaps();
    int b_words, b_f, busy_low;
    logic [31:0] e;
    logic [31:0] word;
    b_words = got_q.size(); b_f = ferr_cnt; busy_low = 0;
    word = 32'hDEAD_BEEF;
    is_data_u8 = 1'b0;
    exp_q.push_back(word);
    for (int k = 3; k >= 0; k--) begin
      cs_low();
      if (k == 2) is_data_u8 = 1'b1;
      send_bits({24'h0, word[k*8 +: 8]}, 8);
      cs_high();
      if (k != 0) begin
        repeat (6) begin
          tick(1);
          if (is_busy !== 1'b1) busy_low++;
        end
      end
    end
    tick(10);
    is_data_u8 = 1'b1;
    n_cmp++; if (busy_low !== 0) begin n_err++; $display("FAIL u32_busy_in_gap low_cycles=%0d exp=0", busy_low); end
    n_cmp++; if (got_q.size() - b_words !== 1) begin n_err++; $display("FAIL u32_word_count got=%0d exp=1", got_q.size() - b_words); end
    e = exp_q.pop_front();
    n_cmp++; if (got_q.size() > b_words && got_q[b_words] !== e) begin n_err++; $display("FAIL u32_data got=%h exp=%h", got_q[b_words], e); end
    n_cmp++; if (ferr_cnt - b_f !== 0) begin n_err++; $display("FAIL u32_no_ferr got=%0d exp=0", ferr_cnt - b_f); end
    n_cmp++; if (is_busy !== 1'b0) begin n_err++; $display("FAIL u32_idle_after got=%b exp=0", is_busy); end
  endtask

  task automatic test_frame_error();
    int b_words, b_f;
    logic [31:0] e;
    b_words = got_q.size(); b_f = ferr_cnt;
    is_data_u8 = 1'b1;
    cs_low(); send_bits(32'h16, 5); cs_high(); tick(10);
    n_cmp++; if (ferr_cnt - b_f !== 1) begin n_err++; $display("FAIL ferr_partial_pulse got=%0d exp=1", ferr_cnt - b_f); end
    n_cmp++; if (got_q.size() - b_words !== 0) begin n_err++; $display("FAIL ferr_partial_no_word got=%0d exp=0", got_q.size() - b_words); end
    exp_q.push_back(32'h0000_003C);
    cs_low(); send_bits(32'h3C, 8); cs_high(); tick(10);
    e = exp_q.pop_front();
    n_cmp++; if (got_q.size() - b_words !== 1 || got_q[got_q.size() - 1] !== e) begin n_err++; $display("FAIL ferr_recover_data got=%h n=%0d exp=%h", got_q[got_q.size() - 1], got_q.size() - b_words, e); end
  endtask

  task automatic test_overrun();
    int b_words, b_o;
    logic [31:0] e;
    b_words = got_q.size(); b_o = ovr_cnt;
    is_data_u8 = 1'b1; out_ready = 1'b0;
    exp_q.push_back(32'h0000_0011);
    cs_low(); send_bits(32'h11, 8); send_bits(32'h22, 8); cs_high(); tick(6);
    n_cmp++; if (ovr_cnt - b_o !== 1) begin n_err++; $display("FAIL ovr_pulse got=%0d exp=1", ovr_cnt - b_o); end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL ovr_valid_held got=%b exp=1", out_valid); end
    n_cmp++; if (out_data !== 32'h0000_0011) begin n_err++; $display("FAIL ovr_data_kept got=%h exp=%h", out_data, 32'h11); end
    out_ready = 1'b1;
    tick(3);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ovr_valid_cleared got=%b exp=0", out_valid); end
    e = exp_q.pop_front();
    n_cmp++; if (got_q.size() - b_words !== 1 || got_q[got_q.size() - 1] !== e) begin n_err++; $display("FAIL ovr_accepted got=%h n=%0d exp=%h", got_q[got_q.size() - 1], got_q.size() - b_words, e); end
  endtask

  task automatic test_gap_timeout();
    int b_words, b_f, early;
    logic [31:0] e;
    b_words = got_q.size(); b_f = ferr_cnt; early = 0;
    is_data_u8 = 1'b0; out_ready = 1'b1;
    cs_low(); send_bits(32'hAB, 8); send_bits(32'hCD, 8); cs_high();
    for (int i = 0; i < 70; i++) begin
      tick(1);
      if (i < 60 && ferr_cnt != b_f) early++;
    end
    n_cmp++; if (early !== 0) begin n_err++; $display("FAIL gap_early_ferr got=%0d exp=0", early); end
    n_cmp++; if (ferr_cnt - b_f !== 1) begin n_err++; $display("FAIL gap_timeout_pulse got=%0d exp=1", ferr_cnt - b_f); end
    n_cmp++; if (is_busy !== 1'b0 || got_q.size() - b_words !== 0) begin n_err++; $display("FAIL gap_idle busy=%b words=%0d exp=0/0", is_busy, got_q.size() - b_words); end
    exp_q.push_back(32'h0102_0304);
    cs_low(); send_bits(32'h0102_0304, 32); cs_high(); tick(10);
    e = exp_q.pop_front();
    n_cmp++; if (got_q.size() - b_words !== 1 || got_q[got_q.size() - 1] !== e) begin n_err++; $display("FAIL gap_next_word got=%h n=%0d exp=%h", got_q[got_q.size() - 1], got_q.size() - b_words, e); end
    is_data_u8 = 1'b1;
  endtask

  task automatic test_reset_mid_byte();
    int b_words;
    logic [31:0] e;
    is_data_u8 = 1'b1;
    cs_low(); send_bits(32'h5, 3);
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({out_data, out_valid, overrun, frame_error, is_busy} !== 36'h0) begin n_err++; $display("FAIL rst_mid_outputs data=%h v=%b o=%b f=%b b=%b exp=all0", out_data, out_valid, overrun, frame_error, is_busy); end
    cs = 1'b1; sclk = 1'b1;
    tick(4);
    n_cmp++; if (is_busy !== 1'b0 || out_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_held busy=%b valid=%b exp=0/0", is_busy, out_valid); end
    rst_n = 1'b1;
    tick(4);
    b_words = got_q.size();
    exp_q.push_back(32'h0000_005A);
    cs_low(); send_bits(32'h5A, 8); cs_high(); tick(10);
    e = exp_q.pop_front();
    n_cmp++; if (got_q.size() - b_words !== 1 || got_q[got_q.size() - 1] !== e) begin n_err++; $display("FAIL rst_mid_recover got=%h n=%0d exp=%h", got_q[got_q.size() - 1], got_q.size() - b_words, e); end
  endtask

  initial begin
    test_reset();
    test_u8();
    test_u32_gaps();
    test_frame_error();
    test_overrun();
    test_gap_timeout();
    test_reset_mid_byte();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_slave_rx.md
# spi_slave_rx

Receive-side SPI endpoint that deserialises the `mosi`/`sclk`/`cs` stream our SPI master produces (mode 3: `sclk` idles high, data changes on falling edge, sampled on rising edge, MSB first). It oversamples the SPI pins in the system `clk` domain and reassembles 8-bit or 32-bit words. Completed words are presented on a one-deep valid/ready output. It is used as a loopback checker and bus-snoop front end for the SSD1306 driver path.

## Interface
- `IDLE_TIMEOUT`, 64: `clk` cycles `cs` may stay high mid-word (32-bit mode) before the partial word is discarded.
- `clk` input 1: reference clock; all logic on rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `sclk` input 1: SPI clock from master, asynchronous to `clk`.
- `mosi` input 1: serial data.
- `cs` input 1: chip select, active low.
- `is_data_u8` input 1: 1 = 8-bit words, 0 = 32-bit words (4 bytes, MSB byte first). Latched per word.
- `out_data` output 32: received word; 8-bit words zero-extended to `[31:8]`.
- `out_valid` output 1: `out_data` holds an unconsumed word.
- `out_ready` input 1: consumer accepts the word when `out_valid && out_ready`.
- `overrun` output 1: one-cycle pulse; a word completed while `out_valid` was high and not accepted that cycle.
- `frame_error` output 1: one-cycle pulse; partial byte or partial word discarded.
- `is_busy` output 1: high in SHIFT or GAP state.

## Operation
- Front end: `sclk`, `mosi` and `cs` pass through conditioning (see Configuration). A registered copy of conditioned `sclk` yields `sclk_rise`.
- `bit_cnt` (3 bits) and `byte_cnt` (2 bits) count within a byte and within a word. `shift_reg` is 32 bits.
- On `sclk_rise` with `cs` low: `shift_reg <= {shift_reg[30:0], mosi}` and `bit_cnt++`.
- When `bit_cnt` wraps 7→0, the byte is complete:
  - u8 mode, or 32-bit mode with `byte_cnt==3`: word complete and `byte_cnt <= 0`.
  - Otherwise `byte_cnt++`.
- `is_data_u8` is latched on the first `sclk_rise` of a word (`bit_cnt==0 && byte_cnt==0`). Changes mid-word are ignored.
- Word complete:
  - If the output slot is free (or is being accepted this cycle): load `out_data` (u8 mode: `{24'h0, shift_reg[7:0]}`) and set `out_valid`.
  - Otherwise: pulse `overrun`; the new word is dropped and `out_data` is unchanged.
- `out_valid` clears on `out_valid && out_ready` unless a new word loads in the same cycle. Load has priority; `out_valid` stays high.
- FSM:
  - IDLE: `cs` high and `byte_cnt==0`. `cs` low → SHIFT.
  - SHIFT: `cs` low.
    - `cs` rises with `bit_cnt!=0` → pulse `frame_error`, clear `bit_cnt`, `byte_cnt` and `shift_reg`, go to IDLE.
    - `cs` rises with `bit_cnt==0 && byte_cnt!=0` → GAP.
    - `cs` rises with `bit_cnt==0 && byte_cnt==0` → IDLE.
  - GAP: `cs` high mid-word. The master releases `cs` between bytes of a 32-bit word. A gap counter starts at 0.
    - `cs` low → SHIFT, word assembly continues.
    - Counter reaches `IDLE_TIMEOUT` → pulse `frame_error`, clear counters, go to IDLE.
- Reset (async assert, any state, including mid-byte): FSM IDLE, all counters and `shift_reg` 0, `out_data` 0, `out_valid` 0, `overrun` 0, `frame_error` 0, `is_busy` 0. Synchroniser flops reset to 1 for `sclk`/`cs` and 0 for `mosi`.

## Timing
- With synchronisers: a pin edge is detected 3 `clk` cycles after it occurs (2 sync stages plus edge register).
- `out_valid` rises 1 cycle after the `sclk_rise` detection of the final bit.
- `sclk` high and low phases must each be ≥4 `clk` cycles. The master's default divider of 20 gives 10.
- `mosi` must be stable from the falling `sclk` edge until after the rising edge. `mosi` and `sclk` travel through identical stages, so skew is preserved.
- `overrun` and `frame_error` are exactly one cycle wide, registered.
- Gap timeout counts `clk` cycles in GAP. The error pulse occurs on cycle `IDLE_TIMEOUT` after entry.

## Configuration
- `SPI_SLAVE_RX_SYNC_EN` defined:
  - Two-flop synchronisers are present on `sclk`, `mosi` and `cs`.
  - Detection latency is 3 cycles.
- `SPI_SLAVE_RX_SYNC_EN` undefined:
  - Pins are used directly. This is only legal when the pins are already synchronous to `clk` (e.g. on-chip loopback from the master).
  - Detection latency is 1 cycle; the minimum `sclk` phase is 2 cycles.
  - All other behaviour is identical.

## Test plan
- u8 mode, send 0xA5, `out_ready`=1 → single `out_valid` cycle, `out_data`=0x000000A5, no error pulses.
- 32-bit mode, send 0xDEADBEEF with `cs` high for 6 cycles between bytes → one word, `out_data`=0xDEADBEEF, `is_busy` high throughout the gaps.
- u8 mode, `cs` rises after 5 bits, then send 0x3C → one `frame_error` pulse, then `out_data`=0x0000003C.
- `out_ready`=0, send 0x11 then 0x22 → `out_data` stays 0x00000011, one `overrun` pulse. Raising `out_ready` clears `out_valid`.
- 32-bit mode, 2 bytes then `cs` high for 70 cycles → `frame_error` on gap cycle 64. Next word 0x01020304 is received intact.
- Assert `rst_n` low mid-byte, release, send 0x5A in u8 mode → all outputs 0 during reset, then `out_data`=0x0000005A.
